// File: rtl/ibuffer_core_pkg.sv
// Shared widths and helpers for the instruction buffer.
package ibuffer_core_pkg;
  localparam int PC_W        = 48;
  localparam int INST_W      = 32;
  localparam int TGT_W       = 32;
  localparam int FETCH_SLOTS = 2;

  // A taken slot0 kills the younger slot1 in the same fetch block.
  function automatic logic [1:0] eff_mask(input logic [1:0] mask, input logic [1:0] taken);
    eff_mask = mask;
    if (mask[0] && taken[0]) eff_mask[1] = 1'b0;
  endfunction
endpackage

// File: rtl/ibuffer_ptr_ctrl.sv
// Pointer, occupancy and full/empty/ready control for the ibuffer FIFO.
module ibuffer_ptr_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_valid,
  input  logic [1:0]               push_cnt,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   wptr,
  output logic [$clog2(DEPTH):0]   rptr,
  output logic                     full,
  output logic                     empty,
  output logic                     fetch_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count;

  always_comb begin
    wptr_d = wptr_q + PW'(push_cnt);
    rptr_d = rptr_q + PW'(pop && !empty);
    if (flush_valid) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  // Ready uses registered occupancy only, so a same-cycle pop gives no credit.
  assign fetch_ready = !reset && !flush_valid && (count <= PW'(DEPTH - 2));
  assign wptr = wptr_q;
  assign rptr = rptr_q;
endmodule

// File: rtl/ibuffer_core.sv
// Show-ahead 2-wide-in / 1-wide-out instruction buffer.
// Optional perf counters enabled by defining IBUFFER_PERF_CNT_EN.
module ibuffer_core
  import ibuffer_core_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush_valid,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [FETCH_SLOTS*INST_W-1:0] fetch_inst,
  input  logic [PC_W-1:0]               fetch_pc,
  input  logic [1:0]                    fetch_slot_mask,
  input  logic [1:0]                    fetch_predicttaken,
  input  logic [TGT_W-1:0]              fetch_predicttarget,
  output logic                          fifo_empty,
  output logic                          ibuffer_instr_valid,
  input  logic                          ibuffer_read_en,
  output logic [INST_W-1:0]             ibuffer_inst_out,
  output logic [PC_W-1:0]               ibuffer_pc_out,
  output logic                          ibuffer_predicttaken_out,
  output logic [TGT_W-1:0]              ibuffer_predicttarget_out
`ifdef IBUFFER_PERF_CNT_EN
  ,
  output logic [63:0]                   perf_full_cycles,
  output logic [63:0]                   perf_empty_cycles,
  output logic [63:0]                   perf_flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic [TGT_W-1:0]  target;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        slot_ent [FETCH_SLOTS];
  entry_t        head;
  logic [AW:0]   wptr, rptr;
  logic          full, empty, accept, pop;
  logic [1:0]    mask_eff, push_cnt;
  logic [AW-1:0] widx0, widx1;

  ibuffer_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clock       (clock),
    .reset       (reset),
    .flush_valid (flush_valid),
    .push_cnt    (push_cnt),
    .pop         (pop),
    .wptr        (wptr),
    .rptr        (rptr),
    .full        (full),
    .empty       (empty),
    .fetch_ready (fetch_ready)
  );

  always_comb begin
    mask_eff = eff_mask(fetch_slot_mask, fetch_predicttaken);
    accept   = fetch_valid && fetch_ready;
    push_cnt = accept ? (2'(mask_eff[0]) + 2'(mask_eff[1])) : 2'd0;
    pop      = ibuffer_read_en && !empty && !flush_valid;
    for (int s = 0; s < FETCH_SLOTS; s++) begin
      slot_ent[s].inst   = fetch_inst[s*INST_W +: INST_W];
      slot_ent[s].pc     = fetch_pc + PC_W'(4 * s);
      slot_ent[s].taken  = fetch_predicttaken[s];
      slot_ent[s].target = fetch_predicttaken[s] ? fetch_predicttarget : '0;
    end
    widx0 = wptr[AW-1:0];
    widx1 = widx0 + 1'b1;
    mem_d = mem_q;
    // Valid slots pack into consecutive entries; widx1 wraps naturally.
    if (accept) begin
      if (mask_eff[0]) begin
        mem_d[widx0] = slot_ent[0];
        if (mask_eff[1]) mem_d[widx1] = slot_ent[1];
      end else if (mask_eff[1]) begin
        mem_d[widx0] = slot_ent[1];
      end
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head                      = mem_q[rptr[AW-1:0]];
  assign fifo_empty                = empty;
  assign ibuffer_instr_valid       = !empty;
  assign ibuffer_inst_out          = empty ? '0 : head.inst;
  assign ibuffer_pc_out            = empty ? '0 : head.pc;
  assign ibuffer_predicttaken_out  = empty ? 1'b0 : head.taken;
  assign ibuffer_predicttarget_out = empty ? '0 : head.target;

`ifdef IBUFFER_PERF_CNT_EN
  logic [63:0] perf_full_q, perf_full_d, perf_empty_q, perf_empty_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_full_d  = perf_full_q + 64'(full);
    perf_empty_d = perf_empty_q + 64'(empty);
    perf_flush_d = perf_flush_q + 64'(flush_valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_full_q  <= perf_full_d;
      perf_empty_q <= perf_empty_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif
endmodule

// File: tb/tb_ibuffer_core.sv
// Randomized + directed bench for ibuffer_core against a queue-based reference model.
module tb_ibuffer_core;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset, flush_valid, fetch_valid, ibuffer_read_en;
  logic        fetch_ready, fifo_empty, ibuffer_instr_valid, ibuffer_predicttaken_out;
  logic [63:0] fetch_inst;
  logic [47:0] fetch_pc, ibuffer_pc_out;
  logic [1:0]  fetch_slot_mask, fetch_predicttaken;
  logic [31:0] fetch_predicttarget, ibuffer_inst_out, ibuffer_predicttarget_out;

  always #5 clock = ~clock;

  ibuffer_core #(.DEPTH(DEPTH)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .flush_valid               (flush_valid),
    .fetch_valid               (fetch_valid),
    .fetch_ready               (fetch_ready),
    .fetch_inst                (fetch_inst),
    .fetch_pc                  (fetch_pc),
    .fetch_slot_mask           (fetch_slot_mask),
    .fetch_predicttaken        (fetch_predicttaken),
    .fetch_predicttarget       (fetch_predicttarget),
    .fifo_empty                (fifo_empty),
    .ibuffer_instr_valid       (ibuffer_instr_valid),
    .ibuffer_read_en           (ibuffer_read_en),
    .ibuffer_inst_out          (ibuffer_inst_out),
    .ibuffer_pc_out            (ibuffer_pc_out),
    .ibuffer_predicttaken_out  (ibuffer_predicttaken_out),
    .ibuffer_predicttarget_out (ibuffer_predicttarget_out)
  );

  typedef struct {
    logic [31:0] inst;
    logic [47:0] pc;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   wr_tot = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [1:0] tk,
                       input logic [47:0] pc, input logic [31:0] tgt, input logic rd,
                       input logic fl);
    fetch_valid         = v;
    fetch_slot_mask     = m;
    fetch_predicttaken  = tk;
    fetch_pc            = pc;
    fetch_predicttarget = tgt;
    fetch_inst          = {$urandom, $urandom};
    ibuffer_read_en     = rd;
    flush_valid         = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 2'b00, 48'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Check outputs against the model for the current inputs, then advance one cycle.
  task automatic step();
    ent_t h;
    logic rdy;
    logic [1:0] m;
    #1;
    rdy = !reset && !flush_valid && ((DEPTH - q.size()) >= 2);
    chk("fetch_ready", {63'b0, fetch_ready}, {63'b0, rdy});
    if (!reset) begin
      h = '{32'h0, 48'h0, 1'b0, 32'h0};
      if (q.size() > 0) h = q[0];
      chk("fifo_empty", {63'b0, fifo_empty}, {63'b0, q.size() == 0});
      chk("instr_valid", {63'b0, ibuffer_instr_valid}, {63'b0, q.size() != 0});
      chk("inst_out", {32'b0, ibuffer_inst_out}, {32'b0, h.inst});
      chk("pc_out", {16'b0, ibuffer_pc_out}, {16'b0, h.pc});
      chk("taken_out", {63'b0, ibuffer_predicttaken_out}, {63'b0, h.tk});
      chk("target_out", {32'b0, ibuffer_predicttarget_out}, {32'b0, h.tgt});
      chk("wptr", 64'(dut.u_ptr.wptr_q), 64'(wr_tot % (2 * DEPTH)));
    end
    if (reset || flush_valid) begin
      q.delete();
      wr_tot = 0;
    end else begin
      if (ibuffer_read_en && q.size() > 0) void'(q.pop_front());
      if (fetch_valid && rdy) begin
        m = fetch_slot_mask;
        if (m[0] && fetch_predicttaken[0]) m[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
          if (m[s]) begin
            q.push_back('{fetch_inst[32*s +: 32], fetch_pc + 48'(4 * s), fetch_predicttaken[s],
                          fetch_predicttaken[s] ? fetch_predicttarget : 32'h0});
            wr_tot++;
          end
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clock);
    step();
    step();
    reset = 1'b0;
    step();

    // Two-slot not-taken block, then two pops in order.
    drive(1'b1, 2'b11, 2'b00, 48'h1000, 32'h0, 1'b0, 1'b0); step();
    idle(); ibuffer_read_en = 1'b1; step(); step(); step();
    idle(); step();
    chk("drained_empty", {63'b0, fifo_empty}, 64'd1);

    // Taken slot0 suppresses slot1.
    drive(1'b1, 2'b11, 2'b01, 48'h3000, 32'h2000, 1'b0, 1'b0); step();
    idle(); step();
    chk("taken_single_entry", 64'(q.size()), 64'd1);
    ibuffer_read_en = 1'b1; step(); idle(); step();

    // Fill to full without pops, then pop from full.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 2'b00, 48'h4000 + 48'(8 * i), 32'h0, 1'b0, 1'b0); step();
    end
    chk("full_occ", 64'(q.size()), 64'd8);
    idle(); ibuffer_read_en = 1'b1; fetch_valid = 1'b1; fetch_slot_mask = 2'b11;
    step(); step(); step(); step();

    // Occupancy 5 with write index 7, then a wrapping 2-slot push with a pop.
    reset = 1'b1; idle(); step(); reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'b01, 2'b00, 48'h5000 + 48'(4 * i), 32'h0, 1'b0, 1'b0); step();
    end
    idle(); ibuffer_read_en = 1'b1; step(); step();
    chk("occ_before_wrap", 64'(q.size()), 64'd5);
    drive(1'b1, 2'b11, 2'b10, 48'h6000, 32'h7777, 1'b1, 1'b0); step();
    chk("occ_after_wrap", 64'(q.size()), 64'd6);
    chk("wrap_bit", 64'(dut.u_ptr.wptr_q[3]), 64'd1);
    idle(); ibuffer_read_en = 1'b1;
    for (int i = 0; i < 7; i++) step();

    // Flush at occupancy 4 with simultaneous push and pop.
    idle();
    drive(1'b1, 2'b11, 2'b00, 48'h8000, 32'h0, 1'b0, 1'b0); step(); step();
    drive(1'b1, 2'b11, 2'b00, 48'h9000, 32'h0, 1'b1, 1'b1); step();
    idle(); step();
    chk("flush_empty", {63'b0, fifo_empty}, 64'd1);

    // Read enable held while empty.
    idle(); ibuffer_read_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("underflow_rptr", 64'(dut.u_ptr.rptr_q), 64'd0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
            {16'h0, $urandom} & 48'hFFFF_FFFC, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 120) == 0);
      step();
    end
    reset = 1'b0; idle(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ibuffer_core.md
IBUFFER_CORE -- requirements
Module: ibuffer_core

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >=4).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush_valid  input  1  discard all buffered and incoming instructions.
REQ-005 SHALL have port fetch_valid  input  1  fetch block offered.
REQ-006 SHALL have port fetch_ready  output  1  block accepted when fetch_valid&&fetch_ready.
REQ-007 SHALL have port fetch_inst  input  64  slot0 [31:0], slot1 [63:32].
REQ-008 SHALL have port fetch_pc  input  48  slot0 PC; slot1 PC = fetch_pc+4.
REQ-009 SHALL have port fetch_slot_mask  input  2  per-slot valid.
REQ-010 SHALL have port fetch_predicttaken  input  2  per-slot predicted-taken.
REQ-011 SHALL have port fetch_predicttarget  input  32  target of taken slot.
REQ-012 SHALL have port fifo_empty  output  1  no entries held.
REQ-013 SHALL have port ibuffer_instr_valid  output  1  head entry valid (= !fifo_empty).
REQ-014 SHALL have ports ibuffer_inst_out 32, ibuffer_pc_out 48, ibuffer_predicttaken_out 1, ibuffer_predicttarget_out 32, all outputs, head entry fields.
REQ-015 SHALL have port ibuffer_read_en  input  1  pop head this cycle.

Function
REQ-016 SHALL be a show-ahead circular FIFO; head fields drive outputs combinationally from storage, zero-latency.
REQ-017 SHALL hold read/write pointers of log2(DEPTH)+1 bits; full when indices equal and wrap bits differ, empty when identical.
REQ-018 SHALL compute effective mask: slot1 cleared when slot0 valid and fetch_predicttaken[0]=1.
REQ-019 SHALL on accept write valid slots in slot order to consecutive entries; count 0..2; mask 00 accepted, writes nothing.
REQ-020 SHALL store per entry {inst, pc, predicttaken bit of that slot, predicttarget if taken else 0}.
REQ-021 SHALL drive fetch_ready = (free entries >= 2) && !flush_valid, from registered occupancy only (pop in same cycle gives no credit).
REQ-022 SHALL ignore ibuffer_read_en when empty; no pointer change.
REQ-023 SHALL allow push and pop in the same cycle; occupancy += pushed - popped.
REQ-024 SHALL on flush_valid reset both pointers next edge, drop any same-cycle push and pop; outputs empty from next cycle.
REQ-025 SHALL wrap pointers modulo DEPTH with wrap bit toggling at index DEPTH-1 -> 0, including a 2-slot write straddling the wrap.
REQ-026 SHALL drive head data outputs to 0 when empty.

Reset
REQ-027 SHALL on reset: pointers 0, fifo_empty=1, ibuffer_instr_valid=0, fetch_ready=0 during reset cycle, data outputs 0.
REQ-028 SHALL give reset priority over flush, push and pop; reset mid-operation discards all contents.
REQ-029 SHALL not require storage arrays to be reset.

Configuration
REQ-030 SHALL with IBUFFER_PERF_CNT_EN defined include 64-bit counters perf_full_cycles (full), perf_empty_cycles (empty), perf_flush_cnt (flushes), as output ports, cleared by reset.
REQ-031 SHALL without IBUFFER_PERF_CNT_EN omit counters and their ports entirely; functional behaviour identical.

Structure
REQ-032 SHALL take widths (PC 48, instruction 32, target 32) from the shared defines package; entry struct layout local.
REQ-033 SHALL have one sub-module ibuffer_ptr_ctrl (pointers, occupancy, full/empty, ready); storage in top.

Verification
REQ-034 SHALL cover: reset, then mask=11 pc=0x1000 not taken -> two pops give pc 0x1000 then 0x1004, then fifo_empty=1.
REQ-035 SHALL cover: mask=11 taken=01 target=0x2000 -> one entry, predicttaken_out=1, target_out=0x2000.
REQ-036 SHALL cover: fill DEPTH=8 without pops -> fetch_ready=0 at occupancy 7 and 8; one pop at 8 -> ready stays 0 that cycle, 1 next.
REQ-037 SHALL cover: occupancy 5 with wptr index 7, push 2 + pop 1 -> occupancy 6, slot1 at index 0, wrap bit toggled, order preserved.
REQ-038 SHALL cover: flush_valid with simultaneous push and read_en at occupancy 4 -> next cycle fifo_empty=1, pushed data never appears.
REQ-039 SHALL cover: read_en held high while empty for 10 cycles -> pointers unchanged, outputs 0, no underflow.
